ccd_frame_capture: RTL and testbench

- Front-end capture stage for the CCD camera path. It sits directly upstream of the Bayer-to-RGB stage.
- Samples the sensor's raw 10-bit pixel bus using the frame-valid and line-valid strobes.
- Gates capture on start/stop requests, always on whole-frame boundaries.
- Produces a pixel-valid strobe, X/Y pixel coordinates whose parity drives Bayer demosaicing, and a completed-frame counter.

---
 rtl/ccd_frame_capture_if.sv | 45 ++++
 rtl/ccd_frame_capture.sv | 184 ++++++++++++++++++
 tb/tb_ccd_frame_capture.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ccd_frame_capture_if.sv
// ---------------------------------------------------------------------------
// ccd_frame_capture_if
// Signal bundle between the CCD sensor front end and the frame capture block.
//   Sensor side (driven by master, read by slave):
//     iDATA   raw 10-bit pixel
//     iFVAL   frame valid
//     iLVAL   line valid
//     iSTART  one-cycle capture start request
//     iEND    one-cycle capture stop request
//   Capture side (driven by slave, read by master):
//     oDATA        captured pixel
//     oDVAL        oDATA valid
//     oX_Cont      column of the pixel on oDATA
//     oY_Cont      row of the pixel on oDATA
//     oFrame_Cont  completed captured frames
//     oCAPTURING   high while capturing or draining
//     oLINE_ERR    sticky short-line flag
// ---------------------------------------------------------------------------
interface ccd_frame_capture_if #(
  parameter int XW = 11,
  parameter int FW = 32
);
  logic [9:0]    iDATA;
  logic          iFVAL;
  logic          iLVAL;
  logic          iSTART;
  logic          iEND;
  logic [9:0]    oDATA;
  logic          oDVAL;
  logic [XW-1:0] oX_Cont;
  logic [XW-1:0] oY_Cont;
  logic [FW-1:0] oFrame_Cont;
  logic          oCAPTURING;
  logic          oLINE_ERR;

  modport master (
    output iDATA, iFVAL, iLVAL, iSTART, iEND,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oCAPTURING, oLINE_ERR
  );

  modport slave (
    input  iDATA, iFVAL, iLVAL, iSTART, iEND,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oCAPTURING, oLINE_ERR
  );
endinterface

// File: rtl/ccd_frame_capture.sv
// ---------------------------------------------------------------------------
// ccd_frame_capture
// Front-end capture stage of the CCD camera path, feeding Bayer-to-RGB.
// Samples the raw sensor bus with FVAL/LVAL, gates capture on start/stop
// requests at whole-frame boundaries, and produces a pixel-valid strobe,
// X/Y coordinates (their parity drives demosaicing) and a frame counter.
// Ports:
//   iCLK  pixel clock
//   iRST  asynchronous active-low reset
//   bus   ccd_frame_capture_if.slave (sensor inputs, capture outputs)
// Latency from iDATA/iFVAL/iLVAL to oDATA/oDVAL is two cycles.
// ---------------------------------------------------------------------------
module ccd_frame_capture #(
  parameter int H_ACTIVE = 1280,
  parameter int XW       = 11,
  parameter int FW       = 32
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  ccd_frame_capture_if.slave   bus
);

  localparam int DATA_W = 10;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] data_p0;
  logic              fval_p0, lval_p0;
  logic              fval_p1, lval_p1;

  logic              fs, fe, le;
  logic              start_req, end_req;
  logic              active, frame_inc, capt_state;
  logic              pix_vld;

  logic [XW-1:0]     x_cnt, y_cnt;
  logic              line_err;
  logic [FW-1:0]     frame_cnt;

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic [XW-1:0]     x_p1, y_p1;
  logic              capturing;

  // ---- stage 1: input registers and edge history ----
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      data_p0 <= '0;
      fval_p0 <= 1'b0;
      lval_p0 <= 1'b0;
      fval_p1 <= 1'b0;
      lval_p1 <= 1'b0;
    end else begin
      data_p0 <= bus.iDATA;
      fval_p0 <= bus.iFVAL;
      lval_p0 <= bus.iLVAL;
      fval_p1 <= fval_p0;
      lval_p1 <= lval_p0;
    end
  end

  assign fs = fval_p0 & ~fval_p1;
  assign fe = ~fval_p0 & fval_p1;
  assign le = lval_p1 & ~lval_p0;

  // A stop request always beats a simultaneous start request.
  assign start_req = bus.iSTART & ~bus.iEND;
  assign end_req   = bus.iEND;

  // ---- control: state register ----
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- control: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = ARMED;
      ARMED:   begin
                 if (end_req) state_nxt = IDLE;
                 else if (fs) state_nxt = CAPTURE;
               end
      CAPTURE: if (end_req) state_nxt = DRAIN;
      // Leaving on ~FVAL covers both the frame end and a drain entered
      // between frames, where there is nothing left to finish.
      DRAIN:   begin
                 if (start_req)     state_nxt = CAPTURE;
                 else if (!fval_p0) state_nxt = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control: outputs ----
  // The FS cycle in ARMED already counts as active so the very first pixel
  // of the frame is not lost when FVAL and LVAL rise together.
  always_comb begin
    active     = 1'b0;
    frame_inc  = 1'b0;
    capt_state = 1'b0;
    case (state)
      ARMED:   active = fs & ~end_req;
      CAPTURE: begin
                 active     = 1'b1;
                 frame_inc  = fe;
                 capt_state = 1'b1;
               end
      DRAIN:   begin
                 active     = 1'b1;
                 frame_inc  = fe;
                 capt_state = 1'b1;
               end
      default: ;
    endcase
  end

  assign pix_vld = fval_p0 & lval_p0 & active;

  // ---- control: coordinates, line error, frame count ----
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      line_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (!active || fe) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (pix_vld) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end else if (le && (x_cnt != '0)) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end

      if (active && le && (x_cnt != '0)) line_err <= 1'b1;
      else if (bus.iSTART)               line_err <= 1'b0;

      if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // ---- stage 2: output registers ----
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      x_p1      <= '0;
      y_p1      <= '0;
      capturing <= 1'b0;
    end else begin
      data_p1   <= (fval_p0 & lval_p0) ? data_p0 : '0;
      vld_p1    <= pix_vld;
      x_p1      <= x_cnt;
      y_p1      <= y_cnt;
      capturing <= capt_state;
    end
  end

  assign bus.oDATA       = data_p1;
  assign bus.oDVAL       = vld_p1;
  assign bus.oX_Cont     = x_p1;
  assign bus.oY_Cont     = y_p1;
  assign bus.oFrame_Cont = frame_cnt;
  assign bus.oCAPTURING  = capturing;
  assign bus.oLINE_ERR   = line_err;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_ccd_frame_capture
// Drives sensor frames (directed and randomized line lengths / pixel data)
// into ccd_frame_capture with H_ACTIVE=4. A frame-level model predicts, for
// every captured frame, the pixel list with coordinates and output cycle,
// the frame count and the sticky short-line flag.
// ---------------------------------------------------------------------------
module tb_ccd_frame_capture;
  localparam int H  = 4;
  localparam int XW = 11;
  localparam int FW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccd_frame_capture_if #(.XW(XW), .FW(FW)) bus();

  ccd_frame_capture #(.H_ACTIVE(H), .XW(XW), .FW(FW)) dut (
    .iCLK(clk),
    .iRST(rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [9:0] d;
    int         x;
    int         y;
    longint     t;
  } pix_t;

  int     checks = 0;
  int     errors = 0;
  longint cyc_n  = 0;
  pix_t   exp_q[$];
  pix_t   mon_e;
  int     exp_frames = 0;
  bit     exp_err    = 1'b0;
  int     line_len[8];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every oDVAL must match the oldest predicted pixel, including its cycle.
  always @(negedge clk) begin
    if (rst_n && bus.oDVAL) begin
      chk("dval_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("pix_data",  64'(bus.oDATA),   64'(mon_e.d));
        chk("pix_x",     64'(bus.oX_Cont), 64'(mon_e.x));
        chk("pix_y",     64'(bus.oY_Cont), 64'(mon_e.y));
        chk("pix_cycle", 64'(cyc_n),       64'(mon_e.t));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit s, input bit e);
    bus.iSTART = s;
    bus.iEND   = e;
    tick();
    bus.iSTART = 1'b0;
    bus.iEND   = 1'b0;
    if (s) exp_err = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dval"},  64'(bus.oDVAL),       64'd0);
    chk({tag, "_data"},  64'(bus.oDATA),       64'd0);
    chk({tag, "_x"},     64'(bus.oX_Cont),     64'd0);
    chk({tag, "_y"},     64'(bus.oY_Cont),     64'd0);
    chk({tag, "_frame"}, 64'(bus.oFrame_Cont), 64'd0);
    chk({tag, "_capt"},  64'(bus.oCAPTURING),  64'd0);
    chk({tag, "_lerr"},  64'(bus.oLINE_ERR),   64'd0);
  endtask

  task automatic chk_state(input string tag, input bit capt);
    chk({tag, "_frames"}, 64'(bus.oFrame_Cont), 64'(exp_frames));
    chk({tag, "_lerr"},   64'(bus.oLINE_ERR),   64'(exp_err));
    chk({tag, "_capt"},   64'(bus.oCAPTURING),  64'(capt));
  endtask

  // One sensor frame of nl lines (lengths in line_len). cap says whether the
  // frame is expected to be captured. end_pix/start_pix pulse iEND/iSTART
  // alongside that pixel index (-1 for none).
  task automatic frame(input int nl, input bit cap, input bit fixed_d,
                       input int end_pix, input int start_pix);
    int  p     = 0;
    int  yb    = 0;
    bit  short = 1'b0;
    pix_t e;
    bus.iFVAL = 1'b1;
    bus.iLVAL = 1'b0;
    repeat ($urandom_range(2, 0)) tick();
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < line_len[l]; i++) begin
        bus.iLVAL  = 1'b1;
        bus.iDATA  = fixed_d ? 10'(p + 1) : 10'($urandom);
        bus.iEND   = (p == end_pix);
        bus.iSTART = (p == start_pix);
        if (cap) begin
          e.d = bus.iDATA;
          e.x = i % H;
          e.y = yb + i / H;
          e.t = cyc_n + 2;
          exp_q.push_back(e);
        end
        tick();
        p++;
      end
      bus.iLVAL  = 1'b0;
      bus.iEND   = 1'b0;
      bus.iSTART = 1'b0;
      if (line_len[l] % H != 0) short = 1'b1;
      yb += (line_len[l] + H - 1) / H;
      repeat ((l == nl - 1) ? $urandom_range(1, 0) : $urandom_range(2, 1)) tick();
    end
    bus.iFVAL = 1'b0;
    repeat (4) tick();
    if (start_pix >= 0) exp_err = 1'b0;
    if (cap) begin
      exp_frames++;
      if (short) exp_err = 1'b1;
    end
  endtask

  initial begin
    pix_t e;
    bus.iDATA  = '0;
    bus.iFVAL  = 1'b0;
    bus.iLVAL  = 1'b0;
    bus.iSTART = 1'b0;
    bus.iEND   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // A frame without iSTART is ignored
    line_len[0] = 4; line_len[1] = 4;
    frame(2, 1'b0, 1'b0, -1, -1);
    chk_state("nostart", 1'b0);

    // Basic capture: 2 lines of 4, data 1..8
    pulse(1'b1, 1'b0);
    tick();
    chk("armed_capt", 64'(bus.oCAPTURING), 64'd0);
    frame(2, 1'b1, 1'b1, -1, -1);
    chk_state("basic", 1'b1);

    // Randomized frames while capturing
    for (int k = 0; k < 4; k++) begin
      int nl;
      nl = $urandom_range(4, 1);
      for (int l = 0; l < nl; l++) line_len[l] = $urandom_range(6, 1);
      frame(nl, 1'b1, 1'b0, -1, -1);
      chk_state("rand", 1'b1);
    end

    // Stop mid line 1: frame completes, then no more capture
    line_len[0] = 4; line_len[1] = 4;
    frame(2, 1'b1, 1'b0, 5, -1);
    chk_state("stop", 1'b0);
    frame(2, 1'b0, 1'b0, -1, -1);
    chk_state("stop_after", 1'b0);

    // Short line: 3 then 4 pixels
    pulse(1'b1, 1'b0);
    tick();
    chk("short_pre_lerr", 64'(bus.oLINE_ERR), 64'd0);
    line_len[0] = 3; line_len[1] = 4;
    frame(2, 1'b1, 1'b0, -1, -1);
    chk_state("short", 1'b1);
    line_len[0] = 4; line_len[1] = 4;
    frame(2, 1'b1, 1'b0, -1, -1);
    chk_state("short_sticky", 1'b1);
    // Stop between frames: drain has nothing to finish
    pulse(1'b0, 1'b1);
    repeat (3) tick();
    chk_state("stop_gap", 1'b0);
    pulse(1'b1, 1'b0);
    tick();
    chk_state("restart_clr", 1'b0);

    // Simultaneous start and stop while armed
    pulse(1'b1, 1'b1);
    tick();
    frame(2, 1'b0, 1'b0, -1, -1);
    chk_state("both", 1'b0);

    // Arm mid-frame: that frame is skipped, next one captured from (0,0)
    frame(2, 1'b0, 1'b0, -1, 3);
    chk_state("midarm", 1'b0);
    frame(2, 1'b1, 1'b0, -1, -1);
    chk_state("midarm_next", 1'b1);
    pulse(1'b0, 1'b1);
    repeat (3) tick();
    chk_state("midarm_stop", 1'b0);

    // Async reset in the middle of a line
    pulse(1'b1, 1'b0);
    tick();
    bus.iFVAL = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.iLVAL = 1'b1;
      bus.iDATA = 10'($urandom);
      e.d = bus.iDATA; e.x = i; e.y = 0; e.t = cyc_n + 2;
      exp_q.push_back(e);
      tick();
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_err    = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    repeat (2) tick();
    bus.iLVAL = 1'b0;
    tick();
    bus.iFVAL = 1'b0;
    repeat (4) tick();
    chk_state("post_rst", 1'b0);
    frame(2, 1'b0, 1'b0, -1, -1);
    chk_state("post_rst_frame", 1'b0);
    pulse(1'b1, 1'b0);
    tick();
    chk("rearm_frames", 64'(bus.oFrame_Cont), 64'd0);
    frame(2, 1'b1, 1'b0, -1, -1);
    chk_state("rearm", 1'b1);

    repeat (4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
